// File: rtl/mod_exp_ctrl.sv
// mod_exp_ctrl: left-to-right binary square-and-multiply sequencer.
// Drives one shared modular multiplier through an enable/done handshake.
// It owns the operand muxing and the running accumulator, and returns
// base^exp mod m.
module mod_exp_ctrl #(
    parameter int NBITS = 4096,
    parameter int EBITS = 4096
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_p,
    input  logic             abort_p,
    input  logic [NBITS-1:0] base,
    input  logic [EBITS-1:0] exp,
    input  logic [NBITS-1:0] m,
    output logic [NBITS-1:0] result,
    output logic             busy,
    output logic             done_irq_p,
    output logic [31:0]      op_cnt,
    output logic             mul_enable_p,
    output logic [NBITS-1:0] mul_a,
    output logic [NBITS-1:0] mul_b,
    output logic [NBITS-1:0] mul_m,
    input  logic [NBITS-1:0] mul_y,
    input  logic             mul_done_irq_p
);

    // Counter wide enough to hold EBITS itself (number of bits still to consume).
    localparam int CW = $clog2(EBITS + 1);

    localparam logic [NBITS-1:0] ZERO_N = {NBITS{1'b0}};
    localparam logic [NBITS-1:0] ONE_N  = {{(NBITS-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]    ZERO_C = {CW{1'b0}};
    localparam logic [CW-1:0]    ONE_C  = {{(CW-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SCAN      = 3'd1,
        NEXT      = 3'd2,
        SQR_ISSUE = 3'd3,
        SQR_WAIT  = 3'd4,
        MUL_ISSUE = 3'd5,
        MUL_WAIT  = 3'd6,
        DONE      = 3'd7
    } state_t;

    state_t           state_r;
    logic [NBITS-1:0] base_r;
    logic [NBITS-1:0] acc_r;
    logic [EBITS-1:0] exp_sh_r;
    logic [CW-1:0]    cnt_r;

    // Sequencer: state, operand registers, accumulator and all registered outputs.
    // mul_m doubles as the latched modulus; it is loaded once per accepted start.
    // The launch pulse and the operands are loaded on entry to an ISSUE state.
    // They become visible during that state and are then held until the matching done.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            base_r       <= ZERO_N;
            acc_r        <= ZERO_N;
            exp_sh_r     <= {EBITS{1'b0}};
            cnt_r        <= ZERO_C;
            result       <= ZERO_N;
            busy         <= 1'b0;
            done_irq_p   <= 1'b0;
            op_cnt       <= 32'd0;
            mul_enable_p <= 1'b0;
            mul_a        <= ZERO_N;
            mul_b        <= ZERO_N;
            mul_m        <= ZERO_N;
        end else begin
            done_irq_p   <= 1'b0;
            mul_enable_p <= 1'b0;
            if (abort_p && (state_r != IDLE) && (state_r != DONE)) begin
                // Abort: drop the run silently; result and op_cnt stay as they are.
                state_r <= IDLE;
                busy    <= 1'b0;
            end else begin
                case (state_r)
                    IDLE: begin
                        if (start_p) begin
                            base_r   <= base;
                            exp_sh_r <= exp;
                            mul_m    <= m;
                            acc_r    <= (m == ONE_N) ? ZERO_N : ONE_N;
                            cnt_r    <= CW'(EBITS);
                            op_cnt   <= 32'd0;
                            busy     <= 1'b1;
                            state_r  <= SCAN;
                        end
                    end
                    SCAN: begin
                        if (cnt_r == ZERO_C) begin
                            result     <= acc_r;
                            done_irq_p <= 1'b1;
                            state_r    <= DONE;
                        end else if (exp_sh_r[EBITS-1]) begin
                            // Leading one: the accumulator becomes base without a multiply.
                            acc_r    <= base_r;
                            exp_sh_r <= {exp_sh_r[EBITS-2:0], 1'b0};
                            cnt_r    <= cnt_r - ONE_C;
                            state_r  <= NEXT;
                        end else begin
                            exp_sh_r <= {exp_sh_r[EBITS-2:0], 1'b0};
                            cnt_r    <= cnt_r - ONE_C;
                        end
                    end
                    NEXT: begin
                        if (cnt_r == ZERO_C) begin
                            result     <= acc_r;
                            done_irq_p <= 1'b1;
                            state_r    <= DONE;
                        end else begin
                            mul_enable_p <= 1'b1;
                            mul_a        <= acc_r;
                            mul_b        <= acc_r;
                            op_cnt       <= op_cnt + 32'd1;
                            state_r      <= SQR_ISSUE;
                        end
                    end
                    SQR_ISSUE: begin
                        state_r <= SQR_WAIT;
                    end
                    SQR_WAIT: begin
                        if (mul_done_irq_p) begin
                            acc_r <= mul_y;
                            if (exp_sh_r[EBITS-1]) begin
                                // The bit stays in place; MUL_WAIT consumes it.
                                mul_enable_p <= 1'b1;
                                mul_a        <= mul_y;
                                mul_b        <= base_r;
                                op_cnt       <= op_cnt + 32'd1;
                                state_r      <= MUL_ISSUE;
                            end else begin
                                exp_sh_r <= {exp_sh_r[EBITS-2:0], 1'b0};
                                cnt_r    <= cnt_r - ONE_C;
                                state_r  <= NEXT;
                            end
                        end
                    end
                    MUL_ISSUE: begin
                        state_r <= MUL_WAIT;
                    end
                    MUL_WAIT: begin
                        if (mul_done_irq_p) begin
                            acc_r    <= mul_y;
                            exp_sh_r <= {exp_sh_r[EBITS-2:0], 1'b0};
                            cnt_r    <= cnt_r - ONE_C;
                            state_r  <= NEXT;
                        end
                    end
                    DONE: begin
                        busy    <= 1'b0;
                        state_r <= IDLE;
                    end
                    default: begin
                        busy    <= 1'b0;
                        state_r <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mod_exp_ctrl.sv
// Bench for mod_exp_ctrl (NBITS=16, EBITS=8) with a behavioural modular multiplier.
module tb_mod_exp_ctrl;

    localparam int NBITS   = 16;
    localparam int EBITS   = 8;
    localparam int MUL_LAT = 3;
    localparam int BOUND   = 3000;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start_p = 1'b0;
    logic             abort_p = 1'b0;
    logic [NBITS-1:0] base = 16'd0;
    logic [EBITS-1:0] exp = 8'd0;
    logic [NBITS-1:0] m = 16'd1;
    logic [NBITS-1:0] result;
    logic             busy;
    logic             done_irq_p;
    logic [31:0]      op_cnt;
    logic             mul_enable_p;
    logic [NBITS-1:0] mul_a;
    logic [NBITS-1:0] mul_b;
    logic [NBITS-1:0] mul_m;
    logic [NBITS-1:0] mul_y;
    logic             mul_done_irq_p;

    int n_checks = 0;
    int n_fail   = 0;
    int en_total = 0;
    int done_total = 0;

    mod_exp_ctrl #(.NBITS(NBITS), .EBITS(EBITS)) dut (
        .clk(clk), .rst_n(rst_n), .start_p(start_p), .abort_p(abort_p),
        .base(base), .exp(exp), .m(m), .result(result), .busy(busy),
        .done_irq_p(done_irq_p), .op_cnt(op_cnt), .mul_enable_p(mul_enable_p),
        .mul_a(mul_a), .mul_b(mul_b), .mul_m(mul_m), .mul_y(mul_y),
        .mul_done_irq_p(mul_done_irq_p)
    );

    always #5 clk = ~clk;

    // Behavioural multiplier: captures operands on enable, answers MUL_LAT+1 cycles later.
    logic        mdl_pend = 1'b0;
    int          mdl_lat  = 0;
    logic [31:0] mdl_prod = 32'd0;
    logic [15:0] mdl_y    = 16'd0;
    logic        mdl_done = 1'b0;
    logic [15:0] cap_a = 16'd0, cap_b = 16'd0, cap_m = 16'd0;

    assign mul_y          = mdl_y;
    assign mul_done_irq_p = mdl_done;

    always @(posedge clk) begin
        mdl_done <= 1'b0;
        if (mdl_pend) begin
            if (mdl_lat == 0) begin
                mdl_done <= 1'b1;
                mdl_y    <= mdl_prod[15:0];
                mdl_pend <= 1'b0;
            end else begin
                mdl_lat <= mdl_lat - 1;
            end
        end else if (mul_enable_p) begin
            mdl_pend <= 1'b1;
            mdl_lat  <= MUL_LAT;
            mdl_prod <= (mul_m == 16'd0) ? 32'd0 : ((32'(mul_a) * 32'(mul_b)) % 32'(mul_m));
            cap_a    <= mul_a;
            cap_b    <= mul_b;
            cap_m    <= mul_m;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Monitor: counts pulses and checks that operands are held while a multiply is pending.
    always @(negedge clk) begin
        if (mul_enable_p) en_total++;
        if (done_irq_p) done_total++;
        if (mul_done_irq_p && busy) begin
            check("operand a held", 32'(mul_a), 32'(cap_a));
            check("operand b held", 32'(mul_b), 32'(cap_b));
            check("operand m held", 32'(mul_m), 32'(cap_m));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch a run and wait (bounded) for done; lat counts edges from the start-sampling edge.
    task automatic run_op(input logic [15:0] b, input logic [7:0] e, input logic [15:0] mm,
                          output int lat, output bit got);
        @(negedge clk);
        base = b; exp = e; m = mm; start_p = 1'b1;
        lat = 0; got = 1'b0;
        for (int k = 0; k < BOUND; k++) begin
            tick();
            start_p = 1'b0;
            lat++;
            if (done_irq_p) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    typedef struct {
        logic [15:0] b;
        logic [7:0]  e;
        logic [15:0] mm;
        logic [15:0] res;
        int          ops;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int lat;
        bit got;
        int en0, d0;

        vecs[0] = '{b: 16'd4,  e: 8'd13,  mm: 16'd497,  res: 16'd445, ops: 5};
        vecs[1] = '{b: 16'd4,  e: 8'd0,   mm: 16'd497,  res: 16'd1,   ops: 0};
        vecs[2] = '{b: 16'd0,  e: 8'd0,   mm: 16'd1,    res: 16'd0,   ops: 0};
        vecs[3] = '{b: 16'd0,  e: 8'd5,   mm: 16'd11,   res: 16'd0,   ops: 3};
        vecs[4] = '{b: 16'd10, e: 8'd255, mm: 16'd11,   res: 16'd10,  ops: 14};
        vecs[5] = '{b: 16'd3,  e: 8'd200, mm: 16'd1000, res: 16'd1,   ops: 9};
        vecs[6] = '{b: 16'd2,  e: 8'd1,   mm: 16'd7,    res: 16'd2,   ops: 0};
        vecs[7] = '{b: 16'd5,  e: 8'd128, mm: 16'd13,   res: 16'd1,   ops: 7};

        // Reset state
        rst_n = 1'b0;
        tick(); tick();
        check("reset result", 32'(result), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done_irq_p), 32'd0);
        check("reset op_cnt", op_cnt, 32'd0);
        check("reset enable", 32'(mul_enable_p), 32'd0);
        check("reset mul_m", 32'(mul_m), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven runs
        for (int i = 0; i < 8; i++) begin
            en0 = en_total; d0 = done_total;
            run_op(vecs[i].b, vecs[i].e, vecs[i].mm, lat, got);
            check($sformatf("vec%0d done seen", i), 32'(got), 32'd1);
            check($sformatf("vec%0d result", i), 32'(result), 32'(vecs[i].res));
            check($sformatf("vec%0d op_cnt", i), op_cnt, 32'(vecs[i].ops));
            check($sformatf("vec%0d busy in done", i), 32'(busy), 32'd1);
            if (vecs[i].e == 8'd0)
                check($sformatf("vec%0d latency", i), 32'(lat), 32'(EBITS + 2));
            tick();
            check($sformatf("vec%0d busy after", i), 32'(busy), 32'd0);
            check($sformatf("vec%0d done single", i), 32'(done_total - d0), 32'd1);
            check($sformatf("vec%0d enables", i), 32'(en_total - en0), 32'(vecs[i].ops));
            repeat (2) tick();
        end

        // Second start mid-run and start during DONE are both ignored
        en0 = en_total; d0 = done_total;
        @(negedge clk);
        base = 16'd4; exp = 8'd13; m = 16'd497; start_p = 1'b1;
        @(negedge clk);
        start_p = 1'b0;
        repeat (6) @(negedge clk);
        base = 16'd7; exp = 8'd255; m = 16'd11; start_p = 1'b1;
        @(negedge clk);
        start_p = 1'b0;
        got = 1'b0;
        for (int k = 0; k < BOUND; k++) begin
            tick();
            if (done_irq_p) begin
                got = 1'b1;
                break;
            end
        end
        check("midstart done seen", 32'(got), 32'd1);
        check("midstart result", 32'(result), 32'd445);
        check("midstart op_cnt", op_cnt, 32'd5);
        base = 16'd3; exp = 8'd1; m = 16'd7; start_p = 1'b1;
        tick();
        start_p = 1'b0;
        check("start in done busy", 32'(busy), 32'd0);
        repeat (3) tick();
        check("start in done still idle", 32'(busy), 32'd0);
        check("midstart done single", 32'(done_total - d0), 32'd1);
        check("midstart result held", 32'(result), 32'd445);

        // Abort while waiting for a square
        d0 = done_total;
        @(negedge clk);
        base = 16'd10; exp = 8'd255; m = 16'd11; start_p = 1'b1;
        got = 1'b0;
        for (int k = 0; k < BOUND; k++) begin
            tick();
            start_p = 1'b0;
            if (mul_enable_p) begin
                got = 1'b1;
                break;
            end
        end
        check("abort first issue seen", 32'(got), 32'd1);
        tick();
        @(negedge clk);
        abort_p = 1'b1;
        tick();
        abort_p = 1'b0;
        check("abort busy", 32'(busy), 32'd0);
        check("abort no done", 32'(done_irq_p), 32'd0);
        check("abort result kept", 32'(result), 32'd445);
        check("abort op_cnt", op_cnt, 32'd1);
        repeat (10) tick();
        check("abort late done ignored busy", 32'(busy), 32'd0);
        check("abort late done ignored cnt", 32'(done_total - d0), 32'd0);
        check("abort result after late", 32'(result), 32'd445);
        check("abort op_cnt frozen", op_cnt, 32'd1);
        run_op(16'd10, 8'd255, 16'd11, lat, got);
        check("post-abort done seen", 32'(got), 32'd1);
        check("post-abort result", 32'(result), 32'd10);
        check("post-abort op_cnt", op_cnt, 32'd14);
        repeat (2) tick();

        // Reset pulse mid-run
        d0 = done_total;
        @(negedge clk);
        base = 16'd3; exp = 8'd200; m = 16'd1000; start_p = 1'b1;
        @(negedge clk);
        start_p = 1'b0;
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midreset result", 32'(result), 32'd0);
        check("midreset busy", 32'(busy), 32'd0);
        check("midreset done", 32'(done_irq_p), 32'd0);
        check("midreset op_cnt", op_cnt, 32'd0);
        check("midreset enable", 32'(mul_enable_p), 32'd0);
        check("midreset mul_a", 32'(mul_a), 32'd0);
        check("midreset mul_b", 32'(mul_b), 32'd0);
        check("midreset mul_m", 32'(mul_m), 32'd0);
        repeat (15) tick();
        check("midreset no done", 32'(done_total - d0), 32'd0);
        check("midreset stays idle", 32'(busy), 32'd0);
        run_op(16'd3, 8'd200, 16'd1000, lat, got);
        check("post-reset done seen", 32'(got), 32'd1);
        check("post-reset result", 32'(result), 32'd1);
        check("post-reset op_cnt", op_cnt, 32'd9);
        repeat (2) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
